serial_rx: RTL and testbench
============================

SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the frame length in bits.
REQ-002 The block SHALL have parameter SYNC, default 2, giving the number of synchronizer flops on each serial input (minimum 2).
REQ-003 Port clk, input, 1, system clock; all state SHALL update on its rising edge only.
REQ-004 Port rst, input, 1, reset; synchronous and active-high.
REQ-005 Port sclk, input, 1, serial clock from the transmitter, asynchronous to clk.
REQ-006 Port data_enable, input, 1, frame enable / chip select, active-high, asynchronous.
REQ-007 Port sdi, input, 1, serial data in, MSB first, changes on falling sclk.
REQ-008 Port data_out, output, WIDTH, last correctly received word.
REQ-009 Port data_valid, output, 1, one-clk pulse marking a new data_out.
REQ-010 Port busy, output, 1, high while a frame is in progress.
REQ-011 Port frame_err, output, 1, one-clk pulse on a short or overlong frame.

Function
REQ-012 sclk, data_enable and sdi SHALL each pass through a SYNC-deep flop chain clocked by clk, with equal depth so all three stay aligned.
REQ-013 An sclk rising edge SHALL be detected as synced sclk low in the previous clk and high in the current clk.
REQ-014 clk frequency SHALL be at least 4x sclk frequency; behaviour below this ratio is undefined.
REQ-015 The FSM SHALL have states IDLE, RECV and DRAIN.
REQ-016 In IDLE, a high synced data_enable SHALL move the FSM to RECV, clear the shift register and clear the bit counter.
REQ-017 In RECV, each detected sclk rising edge with synced data_enable high SHALL shift synced sdi into the shift register LSB and increment the counter.
REQ-018 The counter SHALL be wide enough to hold WIDTH+1 without wrap.
REQ-019 In RECV, synced data_enable low with counter equal to WIDTH SHALL load data_out from the shift register, pulse data_valid for one clk and return to IDLE.
REQ-020 In RECV, synced data_enable low with counter below WIDTH (including 0) SHALL pulse frame_err for one clk, leave data_out unchanged and return to IDLE.
REQ-021 In RECV, an sclk rising edge with counter already at WIDTH SHALL pulse frame_err once and move to DRAIN without shifting.
REQ-022 DRAIN SHALL ignore sclk and return to IDLE on synced data_enable low, with no further pulses.
REQ-023 An sclk edge detected in the same clk as synced data_enable low SHALL NOT be sampled; the enable-low rule applies.
REQ-024 data_valid SHALL assert exactly one clk after the clk in which synced data_enable is first seen low.
REQ-025 data_valid and frame_err SHALL never be high in the same clk.
REQ-026 busy SHALL be high in RECV and DRAIN and low in IDLE.
REQ-027 data_out SHALL hold its value between valid frames.

Reset
REQ-028 When rst is high at a clk edge, the block SHALL set FSM to IDLE, clear counter, shift register and synchronizers to 0, and drive data_out=0, data_valid=0, busy=0 and frame_err=0.
REQ-029 rst asserted mid-frame SHALL abort the frame with no data_valid or frame_err pulse.
REQ-030 After rst, if data_enable is already high, the block SHALL enter RECV once the synced value is high and treat the remainder as a (likely short) frame.

Verification
REQ-031 The bench SHALL cover a normal frame: clk 8x sclk, send 0xA5C3_0F81 MSB first across 32 sclk cycles, then drop enable -> data_out=0xA5C30F81, one data_valid pulse, frame_err stays 0.
REQ-032 The bench SHALL cover back-to-back frames: send 0xFFFFFFFF then 0x00000001 with one idle sclk between -> two data_valid pulses with those values in order.
REQ-033 The bench SHALL cover a short frame: send 20 bits, then drop enable -> one frame_err pulse, data_valid 0, data_out keeps its prior value.
REQ-034 The bench SHALL cover a long frame: send 33 sclk edges before dropping enable -> frame_err pulses once on the 33rd edge, busy stays high until enable falls, no data_valid.
REQ-035 The bench SHALL cover reset mid-frame: assert rst after 10 bits of 0x12345678 -> data_out=0 and no pulses; the next full 0x12345678 frame is received correctly.
REQ-036 The bench SHALL cover an empty frame: enable pulsed high for 3 sclk periods with no sclk edges -> one frame_err pulse.

Source files
------------

// File: rtl/serial_rx_if.sv
// rtl/serial_rx_if.sv - serial receive link: transmitter-side inputs and received-word outputs
interface serial_rx_if #(
  parameter int WIDTH = 32
);
  logic             sclk;
  logic             data_enable;
  logic             sdi;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic             frame_err;

  modport master (
    output sclk, data_enable, sdi,
    input  data_out, data_valid, busy, frame_err
  );

  modport slave (
    input  sclk, data_enable, sdi,
    output data_out, data_valid, busy, frame_err
  );
endinterface

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - oversampled serial frame receiver (MSB first, enable-framed)
// Inputs are synchronized into clk, sclk rises are edge-detected, frames are length-checked.
module serial_rx #(
  parameter int WIDTH = 32,
  parameter int SYNC  = 2
) (
  input  logic        clk,
  input  logic        rst,
  serial_rx_if.slave  rx
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SYNC-1:0]  sclk_sync_q, en_sync_q, sdi_sync_q;
  logic             sclk_prev_q;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic sclk_s, en_s, sdi_s, sclk_rise;

  // All three chains share one depth so sdi stays aligned with its sclk edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      en_sync_q   <= '0;
      sdi_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC-2:0], rx.sclk};
      en_sync_q   <= {en_sync_q[SYNC-2:0], rx.data_enable};
      sdi_sync_q  <= {sdi_sync_q[SYNC-2:0], rx.sdi};
      sclk_prev_q <= sclk_sync_q[SYNC-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC-1];
  assign en_s      = en_sync_q[SYNC-1];
  assign sdi_s     = sdi_sync_q[SYNC-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_s) begin
          state_d = RECV;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      RECV: begin
        // Enable-low wins over a coincident sclk edge.
        if (!en_s) begin
          state_d = IDLE;
          if (cnt_q == FULL) begin
            data_out_d = shift_q;
            valid_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          if (cnt_q == FULL) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            shift_d = {shift_q[WIDTH-2:0], sdi_s};
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!en_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx.data_out   = data_out_q;
  assign rx.data_valid = valid_q;
  assign rx.frame_err  = err_q;
  assign rx.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - directed self-checking bench for serial_rx
module tb_serial_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_rx_if #(.WIDTH(32)) bus ();

  serial_rx #(.WIDTH(32), .SYNC(2)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int valid_cnt    = 0;
  int err_cnt      = 0;
  int both_cnt     = 0;
  logic [31:0] got_words[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.data_valid) begin
        valid_cnt++;
        got_words.push_back(bus.data_out);
      end
      if (bus.frame_err) err_cnt++;
      if (bus.data_valid && bus.frame_err) both_cnt++;
    end
  end

  task automatic clear_counts();
    valid_cnt = 0;
    err_cnt   = 0;
    both_cnt  = 0;
    got_words.delete();
  endtask

  // Half an sclk period: sclk runs at clk/8.
  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int nbits);
    bus.data_enable = 1'b1;
    half();
    for (int i = 0; i < nbits; i++) begin
      bus.sdi = (i < 32) ? v[31 - i] : 1'b0;
      half();
      bus.sclk = 1'b1;
      half();
      bus.sclk = 1'b0;
    end
    half();
  endtask

  task automatic drop_enable();
    bus.data_enable = 1'b0;
    bus.sdi         = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    bus.sclk        = 1'b0;
    bus.data_enable = 1'b0;
    bus.sdi         = 1'b0;
    rst             = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_data_out", bus.data_out, 0);
    check("reset_valid", bus.data_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_err", bus.frame_err, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Normal frame
    clear_counts();
    send_bits(32'hA5C3_0F81, 32);
    check("normal_busy", bus.busy, 1);
    drop_enable();
    check("normal_valid_cnt", valid_cnt, 1);
    check("normal_err_cnt", err_cnt, 0);
    check("normal_data", bus.data_out, 64'hA5C3_0F81);
    check("normal_busy_after", bus.busy, 0);

    // Back-to-back frames with one idle sclk period between
    clear_counts();
    send_bits(32'hFFFF_FFFF, 32);
    bus.data_enable = 1'b0;
    bus.sdi         = 1'b0;
    half();
    half();
    send_bits(32'h0000_0001, 32);
    drop_enable();
    check("b2b_valid_cnt", valid_cnt, 2);
    check("b2b_err_cnt", err_cnt, 0);
    if (got_words.size() == 2) begin
      check("b2b_word0", got_words[0], 64'hFFFF_FFFF);
      check("b2b_word1", got_words[1], 64'h0000_0001);
    end else begin
      check("b2b_word_count", got_words.size(), 2);
    end

    // Short frame: 20 bits
    clear_counts();
    send_bits(32'hDEAD_BEEF, 20);
    drop_enable();
    check("short_err_cnt", err_cnt, 1);
    check("short_valid_cnt", valid_cnt, 0);
    check("short_data_held", bus.data_out, 64'h0000_0001);

    // Long frame: 33 edges, enable held afterwards
    clear_counts();
    send_bits(32'h1357_9BDF, 33);
    check("long_err_on_33", err_cnt, 1);
    check("long_busy_drain", bus.busy, 1);
    half();
    half();
    check("long_busy_hold", bus.busy, 1);
    drop_enable();
    check("long_err_cnt", err_cnt, 1);
    check("long_valid_cnt", valid_cnt, 0);
    check("long_busy_after", bus.busy, 0);
    check("long_data_held", bus.data_out, 64'h0000_0001);

    // Reset mid-frame after 10 bits
    clear_counts();
    send_bits(32'h1234_5678, 10);
    rst             = 1'b1;
    bus.data_enable = 1'b0;
    bus.sdi         = 1'b0;
    bus.sclk        = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_data_out", bus.data_out, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_valid_cnt", valid_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    send_bits(32'h1234_5678, 32);
    drop_enable();
    check("rst_next_valid_cnt", valid_cnt, 1);
    check("rst_next_data", bus.data_out, 64'h1234_5678);

    // Empty frame: enable high for 3 sclk periods, no edges
    clear_counts();
    bus.data_enable = 1'b1;
    repeat (24) @(negedge clk);
    check("empty_busy", bus.busy, 1);
    drop_enable();
    check("empty_err_cnt", err_cnt, 1);
    check("empty_valid_cnt", valid_cnt, 0);
    check("empty_data_held", bus.data_out, 64'h1234_5678);

    check("never_both_pulses", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
